alu_stream_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_stream_unit_alu.sv | 52 +++++
 rtl/alu_stream_unit.sv | 144 ++++++++++++++
 tb/tb_alu_stream_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and its streaming wrapper.
package alu_pkg;

  // Bit positions of the flags inside the 4-bit ALUFlags vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Flags in the same order as ALUFlags: {N, Z, C, V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Raw operation select as carried on the request channel.
  typedef logic [2:0] alu_op_t;

  // Decoded operation encodings understood by the ALU.
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLT   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } alu_opcode_e;

endpackage

// File: rtl/alu_stream_unit_alu.sv
// Combinational ALU: add/sub/logic/set-less-than on N-bit signed operands.
// C and V are only meaningful for ADD/SUB and read 0 for all other ops.
module ALU
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  alu_op_t      Cntr,
  output logic [N-1:0] R,
  output logic [3:0]   ALUFlags
);

  logic         sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum_ext;
  logic         ovf;
  alu_flags_t   flags;

  // Shared adder: subtraction is A + ~B + 1, so C is "no borrow" on SUB.
  always_comb begin
    sub     = (alu_opcode_e'(Cntr) == OP_SUB) || (alu_opcode_e'(Cntr) == OP_SLT);
    b_eff   = sub ? ~B : B;
    sum_ext = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    ovf     = (A[N-1] == b_eff[N-1]) && (sum_ext[N-1] != A[N-1]);
  end

  // Result select and flag generation.
  always_comb begin
    R       = '0;
    flags   = '0;
    case (alu_opcode_e'(Cntr))
      OP_ADD, OP_SUB: begin
        R       = sum_ext[N-1:0];
        flags.c = sum_ext[N];
        flags.v = ovf;
      end
      OP_AND:   R = A & B;
      OP_OR:    R = A | B;
      OP_XOR:   R = A ^ B;
      OP_SLT:   R = {{(N-1){1'b0}}, sum_ext[N-1] ^ ovf};
      OP_PASSA: R = A;
      OP_PASSB: R = B;
      default:  R = '0;
    endcase
    flags.n  = R[N-1];
    flags.z  = (R == '0);
    ALUFlags = flags;
  end

endmodule

// File: rtl/alu_stream_unit.sv
// Two-stage valid/ready wrapper around the ALU with per-request tags,
// sticky flag accumulation and a completed-response counter.
module alu_stream_unit
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_r,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             clr_sticky,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);

  // Stage 0: operands waiting on the ALU.
  logic             s0_valid_q;
  logic [N-1:0]     s0_a_q;
  logic [N-1:0]     s0_b_q;
  alu_op_t          s0_op_q;
  logic [TAG_W-1:0] s0_tag_q;

  // Stage 1: registered ALU result presented on the response channel.
  logic             s1_valid_q;
  logic [N-1:0]     s1_r_q;
  logic [3:0]       s1_flags_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     alu_r;
  logic [3:0]       alu_flags;

  logic advance1, advance0, req_hs, rsp_hs;

  ALU #(.N(N)) u_alu (
    .A        (s0_a_q),
    .B        (s0_b_q),
    .Cntr     (s0_op_q),
    .R        (alu_r),
    .ALUFlags (alu_flags)
  );

  // Handshake and stage-advance terms.
  always_comb begin
    advance1  = !s1_valid_q || rsp_ready;
    advance0  = s0_valid_q && advance1;
    req_ready = !s0_valid_q || advance1;
    req_hs    = req_valid && req_ready;
    // A response shown during a flush is dropped, so it must not be counted.
    rsp_hs    = s1_valid_q && rsp_ready && !flush;
  end

  // Next-state for tag allocator, sticky flags and completion counter.
  always_comb begin
    next_tag_d = next_tag_q;
    sticky_d   = sticky_q;
    count_d    = count_q;
    if (req_hs && !flush) begin
      next_tag_d = next_tag_q + {{(TAG_W-1){1'b0}}, 1'b1};
    end
    if (rsp_hs) begin
      count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      sticky_d = clr_sticky ? s1_flags_q : (sticky_q | s1_flags_q);
    end else if (clr_sticky) begin
      sticky_d = '0;
    end
  end

  // Pipeline registers; flush empties both stages, a new request may refill
  // stage 0 in the same cycle its previous occupant moves to stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_op_q    <= '0;
      s0_tag_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_flags_q <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (flush) begin
        s0_valid_q <= 1'b0;
      end else if (req_hs) begin
        s0_valid_q <= 1'b1;
        s0_a_q     <= req_a;
        s0_b_q     <= req_b;
        s0_op_q    <= req_op;
        s0_tag_q   <= next_tag_q;
      end else if (advance0) begin
        s0_valid_q <= 1'b0;
      end

      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (advance1) begin
        s1_valid_q <= s0_valid_q;
      end

      if (!flush && advance0) begin
        s1_r_q     <= alu_r;
        s1_flags_q <= alu_flags;
        s1_tag_q   <= s0_tag_q;
      end
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag_q <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      next_tag_q <= next_tag_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign rsp_valid    = s1_valid_q;
  assign rsp_r        = s1_r_q;
  assign rsp_flags    = s1_flags_q;
  assign rsp_tag      = s1_tag_q;
  assign sticky_flags = sticky_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_alu_stream_unit.sv
// Directed bench for alu_stream_unit: reset, ADD flags, backpressure,
// streaming with tag wrap, sticky clear, flush and mid-stream reset.
module tb_alu_stream_unit;

  localparam int unsigned N     = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, flush, req_valid, rsp_ready, clr_sticky;
  logic             req_ready, rsp_valid;
  logic [N-1:0]     req_a, req_b, rsp_r;
  logic [2:0]       req_op;
  logic [3:0]       rsp_flags, sticky_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] op_count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  alu_stream_unit #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_r        (rsp_r),
    .rsp_flags    (rsp_flags),
    .rsp_tag      (rsp_tag),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_sticky = 1'b0; rsp_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 3'b000);
    cyc(); cyc();
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_r", {24'd0, rsp_r}, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("rst_count", {16'd0, op_count}, 32'd0);

    // Single ADD 15+10, tag 0.
    rst = 1'b0; rsp_ready = 1'b1;
    drive(1'b1, 8'd15, 8'd10, 3'b000);
    #1 chk("add_req_ready", {31'd0, req_ready}, 32'd1);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("add_s0_only", {31'd0, rsp_valid}, 32'd0);
    cyc();
    #1 chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_rsp_r", {24'd0, rsp_r}, 32'd25);
    chk("add_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("add_rsp_flags", {28'd0, rsp_flags}, 32'h0);
    cyc();
    #1 chk("add_count", {16'd0, op_count}, 32'd1);
    chk("add_rsp_idle", {31'd0, rsp_valid}, 32'd0);

    // Overflow then carry/zero: 127+1 (tag 1), 0xFF+1 (tag 2).
    drive(1'b1, 8'd127, 8'd1, 3'b000);
    cyc(); drive(1'b1, 8'hFF, 8'd1, 3'b000);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("ovf_r", {24'd0, rsp_r}, 32'h80);
    chk("ovf_flags", {28'd0, rsp_flags}, 32'b1001);
    chk("ovf_tag", {28'd0, rsp_tag}, 32'd1);
    cyc();
    #1 chk("zero_r", {24'd0, rsp_r}, 32'h00);
    chk("zero_flags", {28'd0, rsp_flags}, 32'b0110);
    chk("zero_tag", {28'd0, rsp_tag}, 32'd2);
    cyc();
    #1 chk("ovf_sticky", {28'd0, sticky_flags}, 32'b1111);
    chk("ovf_count", {16'd0, op_count}, 32'd3);

    // Reset between tests so backpressure tags start at 0.
    rst = 1'b1;
    cyc(); rst = 1'b0;
    #1 chk("rst2_count", {16'd0, op_count}, 32'd0);
    chk("rst2_sticky", {28'd0, sticky_flags}, 32'd0);

    // Backpressure: ADD 3+4, SUB 5-7, AND F0&3C, XOR 55^55.
    rsp_ready = 1'b0;
    drive(1'b1, 8'd3, 8'd4, 3'b000);
    cyc(); drive(1'b1, 8'd5, 8'd7, 3'b001);
    #1 chk("bp_ready_1", {31'd0, req_ready}, 32'd1);
    cyc(); drive(1'b1, 8'hF0, 8'h3C, 3'b010);
    #1 chk("bp_ready_full", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1 chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_r", {24'd0, rsp_r}, 32'd7);
      chk("bp_hold_tag", {28'd0, rsp_tag}, 32'd0);
      chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    cyc(); drive(1'b1, 8'h55, 8'h55, 3'b100);
    #1 chk("bp_t1_tag", {28'd0, rsp_tag}, 32'd1);
    chk("bp_t1_r", {24'd0, rsp_r}, 32'hFE);
    chk("bp_t1_flags", {28'd0, rsp_flags}, 32'b1000);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("bp_t2_tag", {28'd0, rsp_tag}, 32'd2);
    chk("bp_t2_r", {24'd0, rsp_r}, 32'h30);
    cyc();
    #1 chk("bp_t3_tag", {28'd0, rsp_tag}, 32'd3);
    chk("bp_t3_r", {24'd0, rsp_r}, 32'h00);
    chk("bp_t3_flags", {28'd0, rsp_flags}, 32'b0100);
    cyc();
    #1 chk("bp_count", {16'd0, op_count}, 32'd4);
    chk("bp_idle", {31'd0, rsp_valid}, 32'd0);
    chk("bp_sticky", {28'd0, sticky_flags}, 32'b1100);

    // 20-request stream: a=j, b=j+1 so r=2j+1; tags start at 4 and wrap.
    drive(1'b1, 8'd0, 8'd1, 3'b000);
    for (int j = 1; j <= 21; j++) begin
      cyc();
      if (j < 20) drive(1'b1, 8'(j), 8'(j + 1), 3'b000);
      else drive(1'b0, 8'd0, 8'd0, 3'b000);
      #1;
      if (j >= 2) begin
        chk("str_valid", {31'd0, rsp_valid}, 32'd1);
        chk("str_r", {24'd0, rsp_r}, 32'(2 * (j - 2) + 1));
        chk("str_tag", {28'd0, rsp_tag}, 32'((4 + j - 2) % 16));
        chk("str_ready", {31'd0, req_ready}, 32'd1);
      end
    end
    cyc();
    #1 chk("str_count", {16'd0, op_count}, 32'd24);
    chk("str_idle", {31'd0, rsp_valid}, 32'd0);

    // Sticky clear coinciding with a response of flags 0100 (tag 8).
    drive(1'b1, 8'h5A, 8'h5A, 3'b100);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    cyc();
    #1 chk("clr_rsp_flags", {28'd0, rsp_flags}, 32'b0100);
    chk("clr_rsp_tag", {28'd0, rsp_tag}, 32'd8);
    clr_sticky = 1'b1;
    cyc();
    #1 chk("clr_with_rsp", {28'd0, sticky_flags}, 32'b0100);
    chk("clr_count", {16'd0, op_count}, 32'd25);
    cyc(); clr_sticky = 1'b0;
    #1 chk("clr_alone", {28'd0, sticky_flags}, 32'b0000);

    // Flush with both stages full (tags 9 and 10 discarded).
    rsp_ready = 1'b0;
    drive(1'b1, 8'd1, 8'd2, 3'b000);
    cyc(); drive(1'b1, 8'd3, 8'd4, 3'b000);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("fl_full_ready", {31'd0, req_ready}, 32'd0);
    chk("fl_full_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1; flush = 1'b1;
    cyc(); flush = 1'b0;
    #1 chk("fl_valid", {31'd0, rsp_valid}, 32'd0);
    chk("fl_count", {16'd0, op_count}, 32'd25);
    chk("fl_ready", {31'd0, req_ready}, 32'd1);
    drive(1'b1, 8'd1, 8'd1, 3'b000);
    cyc(); drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("fl_s0_only", {31'd0, rsp_valid}, 32'd0);
    cyc();
    #1 chk("fl_next_tag", {28'd0, rsp_tag}, 32'd11);
    chk("fl_next_r", {24'd0, rsp_r}, 32'd2);
    cyc();
    #1 chk("fl_next_count", {16'd0, op_count}, 32'd26);

    // Reset mid-stream: 127+1 (tag 12) completes, 2+3 (tag 13) shown when rst hits.
    drive(1'b1, 8'd127, 8'd1, 3'b000);
    cyc(); drive(1'b1, 8'd2, 8'd3, 3'b000);
    cyc(); drive(1'b1, 8'd9, 8'd9, 3'b000);
    #1 chk("mid_tag12", {28'd0, rsp_tag}, 32'd12);
    chk("mid_r12", {24'd0, rsp_r}, 32'h80);
    cyc();
    #1 chk("mid_tag13", {28'd0, rsp_tag}, 32'd13);
    chk("mid_sticky", {28'd0, sticky_flags}, 32'b1001);
    chk("mid_count", {16'd0, op_count}, 32'd27);
    rst = 1'b1; clr_sticky = 1'b0; flush = 1'b1;
    cyc(); rst = 1'b0; flush = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 3'b000);
    #1 chk("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_r", {24'd0, rsp_r}, 32'd0);
    chk("mrst_flags", {28'd0, rsp_flags}, 32'd0);
    chk("mrst_tag", {28'd0, rsp_tag}, 32'd0);
    chk("mrst_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("mrst_count", {16'd0, op_count}, 32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
